// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stall FSM, memory freeze and branch flush.
// Optional performance counters enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int unsigned LU_STALL_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_memread,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_flush,
   output logic       idex_flush
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   localparam int unsigned CNT_W      = 2;
   localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LU_STALL_CYCLES - 1);
   localparam bit          MULTI_STALL = (LU_STALL_CYCLES > 1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              freeze;
   logic              hazard;
   logic              stall_act;
   logic              flush_act;

   assign freeze = mem_req & ~mem_ready;
   assign hazard = ex_memread & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd)));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and combinational pipeline controls, priority freeze > branch > stall
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall_act  = 1'b0;
      flush_act  = 1'b0;

      if (reset) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_en    = 1'b0;
         exmem_en   = 1'b0;
         memwb_en   = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = RUN;
         cnt_d      = '0;
      end else if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         flush_act  = 1'b1;
         state_d    = RUN;
         cnt_d      = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (hazard) begin
                  stall_act = 1'b1;
                  if (MULTI_STALL) begin
                     state_d = LU_STALL;
                     cnt_d   = STALL_INIT;
                  end
               end
            end
            LU_STALL: begin
               stall_act = 1'b1;
               // cnt <= 1 also recovers from an unreachable zero count
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase

         if (stall_act) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   localparam int unsigned PERF_W = 16;
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if ((freeze | stall_act) && (stall_q != PERF_MAX)) begin
            stall_q <= stall_q + PERF_W'(1);
         end
         if (flush_act && (flush_q != PERF_MAX)) begin
            flush_q <= flush_q + PERF_W'(1);
         end
      end
   end

   // Counters read zero for the whole reset interval, including its first cycle
   assign stall_cycles = reset ? '0 : stall_q;
   assign flush_count  = reset ? '0 : flush_q;
`endif

endmodule
